// File: rtl/digit_pipeline_ctrl_if.sv
// Bundle of host, engine and BRAM signals around the
// digit pipeline sequencer; slave = controller side.
interface digit_pipeline_ctrl_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16,
  parameter int RES_W  = 4
);
  logic              host_start;
  logic              host_ready;
  logic              host_done;
  logic [RES_W-1:0]  host_result;
  logic              host_err;
  logic [ADDR_W-1:0] host_addr;
  logic              host_en;
  logic              host_we;
  logic [DATA_W-1:0] host_wdata;

  logic              dsk_start;
  logic              dsk_ready;
  logic              dsk_done;
  logic [ADDR_W-1:0] dsk_addr;
  logic              dsk_en;
  logic              dsk_we;
  logic [DATA_W-1:0] dsk_wdata;

  logic              cls_start;
  logic              cls_ready;
  logic              cls_done;
  logic [RES_W-1:0]  cls_result;
  logic [ADDR_W-1:0] cls_addr;
  logic              cls_en;
  logic              cls_we;
  logic [DATA_W-1:0] cls_wdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output host_start, host_addr, host_en,
           host_we, host_wdata,
    output dsk_ready, dsk_done, dsk_addr,
           dsk_en, dsk_we, dsk_wdata,
    output cls_ready, cls_done, cls_result,
           cls_addr, cls_en, cls_we, cls_wdata,
    output mem_rdata,
    input  host_ready, host_done, host_result,
           host_err, dsk_start, cls_start,
    input  mem_addr, mem_en, mem_we, mem_wdata
  );

  modport slave (
    input  host_start, host_addr, host_en,
           host_we, host_wdata,
    input  dsk_ready, dsk_done, dsk_addr,
           dsk_en, dsk_we, dsk_wdata,
    input  cls_ready, cls_done, cls_result,
           cls_addr, cls_en, cls_we, cls_wdata,
    input  mem_rdata,
    output host_ready, host_done, host_result,
           host_err, dsk_start, cls_start,
    output mem_addr, mem_en, mem_we, mem_wdata
  );
endinterface

// File: rtl/digit_pipeline_ctrl.sv
// Job sequencer: host -> deskew -> classifier, owns image BRAM mux.
// Optional watchdog: define DIGIT_PIPELINE_WATCHDOG_EN.
module digit_pipeline_ctrl #(
  parameter int ADDR_W         = 11,
  parameter int DATA_W         = 16,
  parameter int RES_W          = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic clk,
  input logic reset,
  digit_pipeline_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, DSK_ARM, DSK_RUN,
    CLS_ARM, CLS_RUN, FIN
  } state_t;

  state_t state_q, state_d;
  logic   dsk_start, cls_start;
  logic   timeout;
  logic   done_q;
  logic [RES_W-1:0] result_q;

  logic dsk_fin, cls_fin, in_eng;
  assign dsk_fin = (state_q == DSK_RUN) && bus.dsk_done;
  assign cls_fin = (state_q == CLS_RUN) && bus.cls_done;
  assign in_eng  = (state_q != IDLE) && (state_q != FIN);

`ifdef DIGIT_PIPELINE_WATCHDOG_EN
  localparam logic [15:0] WD_LAST =
    16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_q;
  logic        err_q;
  logic        arm_entry;

  // a finishing engine beats a simultaneous timeout
  assign timeout = in_eng && (wd_q == WD_LAST)
                && !dsk_fin && !cls_fin;
  assign arm_entry =
    (state_d == DSK_ARM && state_q != DSK_ARM) ||
    (state_d == CLS_ARM && state_q != CLS_ARM);

  // per-phase cycle counter, restarts at each ARM entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          wd_q <= '0;
    else if (arm_entry) wd_q <= '0;
    else if (in_eng)    wd_q <= wd_q + 16'd1;
    else                wd_q <= '0;
  end

  // sticky error, cleared when the next job is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else if (state_q == IDLE && bus.host_start)
      err_q <= 1'b0;
    else if (timeout) err_q <= 1'b1;
  end

  assign bus.host_err = err_q;
`else
  assign timeout      = 1'b0;
  assign bus.host_err = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state and engine start strobes
  always_comb begin
    state_d   = state_q;
    dsk_start = 1'b0;
    cls_start = 1'b0;
    unique case (state_q)
      IDLE:
        if (bus.host_start) state_d = DSK_ARM;
      DSK_ARM:
        if (timeout) state_d = IDLE;
        else if (bus.dsk_ready) begin
          dsk_start = 1'b1;
          state_d   = DSK_RUN;
        end
      DSK_RUN:
        if (timeout)      state_d = IDLE;
        else if (dsk_fin) state_d = CLS_ARM;
      CLS_ARM:
        if (timeout) state_d = IDLE;
        else if (bus.cls_ready) begin
          cls_start = 1'b1;
          state_d   = CLS_RUN;
        end
      CLS_RUN:
        if (timeout)      state_d = IDLE;
        else if (cls_fin) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // result capture and one-cycle done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= cls_fin || timeout;
      if (state_q == IDLE && bus.host_start)
        result_q <= '0;
      else if (cls_fin)
        result_q <= bus.cls_result;
    end
  end

  logic own_host, own_dsk, own_cls;
  assign own_host = (state_q == IDLE);
  assign own_dsk  = (state_q == DSK_ARM) ||
                    (state_q == DSK_RUN);
  assign own_cls  = (state_q == CLS_ARM) ||
                    (state_q == CLS_RUN);

  // BRAM owner mux, no register stage
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    unique case (1'b1)
      own_host: begin
        bus.mem_addr  = bus.host_addr;
        bus.mem_en    = bus.host_en;
        bus.mem_we    = bus.host_we;
        bus.mem_wdata = bus.host_wdata;
      end
      own_dsk: begin
        bus.mem_addr  = bus.dsk_addr;
        bus.mem_en    = bus.dsk_en;
        bus.mem_we    = bus.dsk_we;
        bus.mem_wdata = bus.dsk_wdata;
      end
      own_cls: begin
        bus.mem_addr  = bus.cls_addr;
        bus.mem_en    = bus.cls_en;
        bus.mem_we    = bus.cls_we;
        bus.mem_wdata = bus.cls_wdata;
      end
      default: ;
    endcase
  end

  assign bus.host_ready  = own_host;
  assign bus.host_done   = done_q;
  assign bus.host_result = result_q;
  assign bus.dsk_start   = dsk_start;
  assign bus.cls_start   = cls_start;

endmodule

// File: doc/digit_pipeline_ctrl.md
# digit_pipeline_ctrl

Top-level job sequencer for the digit-recognition accelerator. It accepts one image-classification job from the host, runs the deskew engine, then runs the SVM classifier, and returns the classifier result with a one-cycle done pulse. It also owns the single-port image BRAM (raw image at 0..783, deskewed image at 784..1567). It multiplexes that BRAM between the host loader, the deskew engine and the classifier according to the job phase.

## Interface
Parameters:
- ADDR_W, 11, BRAM address width
- DATA_W, 16, BRAM data width
- RES_W, 4, classifier result width (digit 0..9)
- TIMEOUT_CYCLES, 65535, watchdog limit per engine phase; legal range 1..65535, counter is 16 bits

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; all state clears immediately
- host_start  in  1  job request, sampled only in IDLE
- host_ready  out  1  high exactly when state==IDLE
- host_done  out  1  one-cycle completion pulse
- host_result  out  RES_W  last classification result, held until the next accepted job
- host_err  out  1  sticky timeout flag
- host_addr / host_en / host_we / host_wdata  in  ADDR_W/1/1/DATA_W  host BRAM port
- dsk_start  out  1  deskew start strobe
- dsk_ready  in  1  deskew idle
- dsk_done  in  1  deskew done pulse
- dsk_addr / dsk_en / dsk_we / dsk_wdata  in  ADDR_W/1/1/DATA_W  deskew BRAM port
- cls_start  out  1  classifier start strobe
- cls_ready  in  1  classifier idle
- cls_done  in  1  classifier done pulse
- cls_result  in  RES_W  valid in the cls_done cycle
- cls_addr / cls_en / cls_we / cls_wdata  in  ADDR_W/1/1/DATA_W  classifier BRAM port
- mem_addr / mem_en / mem_we / mem_wdata  out  ADDR_W/1/1/DATA_W  shared BRAM port
- mem_rdata  in  DATA_W  BRAM read data, broadcast unchanged to all requesters

## Operation
- States: IDLE, DSK_ARM, DSK_RUN, CLS_ARM, CLS_RUN, FIN.
- IDLE:
  - host owns the BRAM.
  - On host_start=1, clear host_err and host_result, then go to DSK_ARM.
- DSK_ARM:
  - Deskew owns the BRAM.
  - Wait for dsk_ready=1.
  - In the first cycle with dsk_ready=1, drive dsk_start=1 for that cycle only, then go to DSK_RUN.
- DSK_RUN:
  - Deskew owns the BRAM.
  - On dsk_done=1, go to CLS_ARM.
- CLS_ARM / CLS_RUN:
  - Same handshake as the deskew phase, using cls_ready, cls_start and cls_done.
  - The classifier owns the BRAM.
  - On cls_done=1, register cls_result into host_result and go to FIN.
- FIN:
  - host_done=1 for one cycle.
  - Nobody owns the BRAM; mem_en=0.
  - Go to IDLE.
- BRAM mux:
  - Purely combinational from state; the owner's addr/en/we/wdata pass through to mem_*.
  - Non-owner en/we are ignored. Host accesses outside IDLE are dropped silently.
  - Non-owner read data on mem_rdata is meaningless to it.
- Done pulses arriving in a state that does not expect them are ignored.
- host_start outside IDLE is ignored; there is no queueing.

## Timing
- Reset values:
  - state=IDLE
  - host_ready=1
  - host_done=0, host_result=0, host_err=0
  - dsk_start=0, cls_start=0
  - Watchdog counter = 0
  - mem_* follows the host port
- Latency with engines already ready:
  - host_start at cycle T gives dsk_start at T+1.
  - dsk_done at D gives cls_start at D+1.
  - cls_done at C gives host_done and the new host_result at C+1, and host_ready at C+2.
- Overhead is 4 controller cycles per job plus engine time.
- BRAM read latency is the BRAM's own (1 cycle). The controller adds no register stage on mem_*.
- Reset asserted mid-job aborts immediately to IDLE. The engines are reset by their own reset; the controller does not wait for them.

## Configuration
- DIGIT_PIPELINE_WATCHDOG_EN defined:
  - A 16-bit counter clears on entry to each ARM state and increments every cycle in ARM/RUN states.
  - When it reaches TIMEOUT_CYCLES, set host_err=1, pulse host_done, go to IDLE, and leave host_result=0.
  - If a done pulse arrives in the same cycle as the timeout, the done pulse wins and the timeout is not flagged.
- DIGIT_PIPELINE_WATCHDOG_EN undefined:
  - No counter is built; host_err is tied to 0.
  - ARM and RUN states wait indefinitely.

## Test plan
- Reset, then host writes 784 pixels at addresses 0..783 in IDLE -> all 784 writes appear on mem_* with mem_we=1; host_ready=1 throughout.
- host_start at T; model deskew drives dsk_done at T+10000 and classifier returns cls_result=7 -> dsk_start at T+1, cls_start at T+10001, host_done and host_result=7 one cycle after cls_done, host_ready=1 the cycle after.
- Host asserts host_en/host_we to address 5 during DSK_RUN -> mem_* carries the deskew port only; no host write reaches the BRAM.
- dsk_ready held 0 for 20 cycles after host_start -> dsk_start stays 0, then pulses exactly once in the first cycle dsk_ready=1.
- With DIGIT_PIPELINE_WATCHDOG_EN and TIMEOUT_CYCLES=100, the classifier never returns done -> after 100 cycles in CLS_ARM/CLS_RUN, host_err=1, host_done pulse, host_result=0; the next host_start clears host_err.
- Reset asserted during CLS_RUN -> outputs return to their reset values in the same cycle, and a new job runs correctly after reset is released.
